// File: rtl/gate_checker.sv
// gate_checker: sweeps the gate box inputs through 00,01,10,11 and checks
// all six gate outputs against their truth table after a settle time.
module gate_checker #(
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       nd,
   input  logic       r,
   input  logic       nnd,
   input  logic       nr,
   input  logic       xr,
   input  logic       nxr,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] err_mask,
   output logic [1:0] vec
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [3:0] CNT_LAST = 4'(HOLD_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic       a_q, a_d;
   logic       b_q, b_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [2:0] err_cnt_q, err_cnt_d;
   logic [3:0] err_mask_q, err_mask_d;
   logic [5:0] exp_w;
   logic [5:0] got_w;
   logic       match_w;

   assign exp_w = {a_q & b_q, a_q | b_q,
                   ~(a_q & b_q), ~(a_q | b_q),
                   a_q ^ b_q, ~(a_q ^ b_q)};
   assign got_w = {nd, r, nnd, nr, xr, nxr};
   // case equality so an X/Z gate output counts as a failure
   assign match_w = (got_w === exp_w);

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_cnt_d  = err_cnt_q;
      err_mask_d = err_mask_q;
      case (state_q)
         S_DRIVE: begin
            if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               if (!match_w) begin
                  err_mask_d[vec_q] = 1'b1;
                  if (err_cnt_q != 3'd4)
                     err_cnt_d = err_cnt_q + 3'd1;
               end
               if (vec_q != 2'd3) begin
                  vec_d = vec_q + 2'd1;
                  cnt_d = 4'd0;
                  a_d   = vec_d[1];
                  b_d   = vec_d[0];
               end else begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            // idle and done both launch a fresh sweep
            if (start) begin
               state_d    = S_DRIVE;
               vec_d      = 2'd0;
               cnt_d      = 4'd0;
               a_d        = 1'b0;
               b_d        = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               err_cnt_d  = 3'd0;
               err_mask_d = 4'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         vec_q      <= 2'd0;
         cnt_q      <= 4'd0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_cnt_q  <= 3'd0;
         err_mask_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_cnt_q  <= err_cnt_d;
         err_mask_q <= err_mask_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_count = err_cnt_q;
   assign err_mask  = err_mask_q;
   assign vec       = vec_q;
   assign pass      = done_q & (err_cnt_q == 3'd0);

endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: three checkers (hold 1, 2, 15) each driving a
// configurable faulty gate box, checked against a sweep-timeline model.
module tb_gate_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_s[3];
   logic       a_w[3], b_w[3];
   logic       busy_w[3], done_w[3], pass_w[3];
   logic [2:0] ec_w[3];
   logic [3:0] em_w[3];
   logic [1:0] vec_w[3];
   logic       la[3], lb[3];
   logic [5:0] box[3];
   int         mode[3];
   int         checks = 0;
   int         errors = 0;
   bit         chk_en = 1'b0;

   int         t[3] = '{-1, -1, -1};
   bit         mdone[3];
   int         mcnt[3];
   bit [3:0]   mmask[3];
   bit         ma[3], mb[3], ma1[3], mb1[3];
   int         mvec[3];

   always #5 clk = ~clk;

   function automatic int hold(int i);
      return (i == 0) ? 1 : (i == 1) ? 2 : 15;
   endfunction

   function automatic logic [5:0] gates(logic x, logic y);
      return {x & y, x | y, !(x & y), !(x | y), x ^ y, !(x ^ y)};
   endfunction

   // 0 good, 1 xr stuck-0, 2 nxr=a^b, 3 all outputs one cycle late
   function automatic logic [5:0] boxf(int md, logic x, logic y,
                                       logic lx, logic ly);
      logic [5:0] g;
      g = gates(x, y);
      case (md)
         1: g[1] = 1'b0;
         2: g[0] = x ^ y;
         3: g = gates(lx, ly);
         default: ;
      endcase
      return g;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++)
         box[i] = boxf(mode[i], a_w[i], b_w[i], la[i], lb[i]);
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         la[i] <= a_w[i];
         lb[i] <= b_w[i];
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_dut
      gate_checker #(
         .HOLD_CYCLES(g == 0 ? 1 : g == 1 ? 2 : 15)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start_s[g]),
         .a(a_w[g]), .b(b_w[g]),
         .nd(box[g][5]), .r(box[g][4]), .nnd(box[g][3]),
         .nr(box[g][2]), .xr(box[g][1]), .nxr(box[g][0]),
         .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]),
         .err_count(ec_w[g]), .err_mask(em_w[g]), .vec(vec_w[g])
      );
   end

   // t = cycles since the start edge, -1 when not sweeping
   always @(posedge clk) begin
      bit ca, cb, pa, pb;
      int h, v;
      for (int i = 0; i < 3; i++) begin
         h = hold(i);
         ca = ma[i]; cb = mb[i];
         pa = ma1[i]; pb = mb1[i];
         ma1[i] = ma[i]; mb1[i] = mb[i];
         if (!rst_n) begin
            t[i] = -1; mdone[i] = 0; mcnt[i] = 0; mmask[i] = 0;
            ma[i] = 0; mb[i] = 0; mvec[i] = 0;
         end else if (t[i] < 0) begin
            if (start_s[i]) begin
               t[i] = 0; mdone[i] = 0; mcnt[i] = 0; mmask[i] = 0;
               ma[i] = 0; mb[i] = 0; mvec[i] = 0;
            end
         end else begin
            t[i]++;
            if (t[i] % h == 0) begin
               v = t[i] / h - 1;
               if (boxf(mode[i], ca, cb, pa, pb) != gates(ca, cb)) begin
                  mmask[i][v] = 1'b1;
                  mcnt[i]++;
               end
            end
            if (t[i] == 4 * h) begin
               t[i] = -1;
               mdone[i] = 1;
            end else begin
               mvec[i] = t[i] / h;
               ma[i] = mvec[i][1];
               mb[i] = mvec[i][0];
            end
         end
      end
   end

   task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h want %0h at %0t",
                  nm, i, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         chk("a", i, 32'(a_w[i]), 32'(ma[i]));
         chk("b", i, 32'(b_w[i]), 32'(mb[i]));
         chk("busy", i, 32'(busy_w[i]), 32'(t[i] >= 0));
         chk("done", i, 32'(done_w[i]), 32'(mdone[i]));
         chk("pass", i, 32'(pass_w[i]), 32'(mdone[i] && mcnt[i] == 0));
         chk("err_count", i, 32'(ec_w[i]), 32'(mcnt[i]));
         chk("err_mask", i, 32'(em_w[i]), 32'(mmask[i]));
         if (t[i] >= 0)
            chk("vec", i, 32'(vec_w[i]), 32'(mvec[i]));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_en) compare_all();
   endtask

   task automatic pulse(int i);
      start_s[i] = 1'b1;
      tick();
      start_s[i] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_s[i] = 1'b0;
         mode[i] = 0;
      end
      repeat (3) tick();
      chk_en = 1'b1;
      tick();
      chk("rst_busy", 1, 32'(busy_w[1]), 0);
      chk("rst_done", 1, 32'(done_w[1]), 0);
      chk("rst_mask", 1, 32'(em_w[1]), 0);
      rst_n = 1'b1;
      tick();

      // golden sweep with a second start while busy
      pulse(1);
      tick(); tick();
      chk("step_a", 1, 32'(a_w[1]), 0);
      chk("step_b", 1, 32'(b_w[1]), 1);
      start_s[1] = 1'b1;
      tick();
      start_s[1] = 1'b0;
      repeat (4) tick();
      chk("gold_done_k7", 1, 32'(done_w[1]), 0);
      tick();
      chk("gold_done_k8", 1, 32'(done_w[1]), 1);
      chk("gold_pass", 1, 32'(pass_w[1]), 1);
      chk("gold_mask", 1, 32'(em_w[1]), 0);

      mode[1] = 1;
      pulse(1);
      repeat (9) tick();
      chk("stuck_mask", 1, 32'(em_w[1]), 32'h6);
      chk("stuck_cnt", 1, 32'(ec_w[1]), 2);
      chk("stuck_pass", 1, 32'(pass_w[1]), 0);

      mode[1] = 2;
      pulse(1);
      repeat (9) tick();
      chk("xnor_mask", 1, 32'(em_w[1]), 32'hf);
      chk("xnor_cnt", 1, 32'(ec_w[1]), 4);

      mode[1] = 0;
      pulse(1);
      chk("restart_cnt", 1, 32'(ec_w[1]), 0);
      chk("restart_mask", 1, 32'(em_w[1]), 0);
      chk("restart_vec", 1, 32'(vec_w[1]), 0);
      chk("restart_busy", 1, 32'(busy_w[1]), 1);

      repeat (4) tick();
      chk("mid_vec", 1, 32'(vec_w[1]), 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_a", 1, 32'(a_w[1]), 0);
      chk("mid_rst_busy", 1, 32'(busy_w[1]), 0);
      repeat (10) tick();
      chk("quiet_busy", 1, 32'(busy_w[1]), 0);
      chk("quiet_done", 1, 32'(done_w[1]), 0);

      pulse(0);
      repeat (3) tick();
      chk("h1_done_k3", 0, 32'(done_w[0]), 0);
      tick();
      chk("h1_done_k4", 0, 32'(done_w[0]), 1);
      pulse(2);
      repeat (59) tick();
      chk("h15_done_k59", 2, 32'(done_w[2]), 0);
      tick();
      chk("h15_done_k60", 2, 32'(done_w[2]), 1);
      chk("h15_pass", 2, 32'(pass_w[2]), 1);

      mode[0] = 3;
      mode[1] = 3;
      start_s[0] = 1'b1;
      start_s[1] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      repeat (10) tick();
      chk("late_h1_pass", 0, 32'(pass_w[0]), 0);
      chk("late_h2_pass", 1, 32'(pass_w[1]), 1);

      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom % 150) != 0;
         for (int i = 0; i < 3; i++) begin
            start_s[i] = ($urandom % 12) == 0;
            if ($urandom % 25 == 0) mode[i] = int'($urandom % 4);
         end
         tick();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) start_s[i] = 1'b1;
      repeat (100) tick();
      for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
      repeat (70) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
